// File: rtl/i2c_target_regs.sv
// I2C target responder: filtered SCL/SDA front end, 7-bit address match, register pointer,
// and burst write/read access to a simple one-cycle-latency register port.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h33,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  inout  wire        b_sda,
  input  logic       b_scl,
  output logic       o_reg_we,
  output logic       o_reg_re,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy,
  output logic       o_start,
  output logic       o_stop
);

  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_PTR      = 4'd3;
  localparam logic [3:0] ST_PTR_ACK  = 4'd4;
  localparam logic [3:0] ST_WR       = 4'd5;
  localparam logic [3:0] ST_WR_ACK   = 4'd6;
  localparam logic [3:0] ST_RD       = 4'd7;
  localparam logic [3:0] ST_RD_ACK   = 4'd8;
  localparam logic [3:0] ST_IGNORE   = 4'd9;

  logic             scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic             sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
  logic             scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic             scl_p_q, scl_p_d, sda_p_q, sda_p_d;

  logic [3:0] state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic [7:0] tx_q, tx_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rd_load_q, rd_load_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;

  // Synchronizer and glitch filter; both lines share identical latency.
  always_comb begin
    scl_s1_d  = b_scl;
    scl_s2_d  = scl_s1_q;
    sda_s1_d  = b_sda;
    sda_s2_d  = sda_s1_q;
    scl_p_d   = scl_f_q;
    sda_p_d   = sda_f_q;
    scl_f_d   = scl_f_q;
    scl_cnt_d = CNT_ZERO;
    sda_f_d   = sda_f_q;
    sda_cnt_d = CNT_ZERO;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == FILT_MAX) begin
        scl_f_d   = scl_s2_q;
        scl_cnt_d = CNT_ZERO;
      end else begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = scl_cnt_q + CNT_ONE;
      end
    end else begin
      scl_f_d   = scl_f_q;
      scl_cnt_d = CNT_ZERO;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == FILT_MAX) begin
        sda_f_d   = sda_s2_q;
        sda_cnt_d = CNT_ZERO;
      end else begin
        sda_f_d   = sda_f_q;
        sda_cnt_d = sda_cnt_q + CNT_ONE;
      end
    end else begin
      sda_f_d   = sda_f_q;
      sda_cnt_d = CNT_ZERO;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign shift_in  = {shift_q, sda_f_q};

  // Protocol FSM, pointer and register-port strobes.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    tx_d        = tx_q;
    sda_oe_d    = sda_oe_q;
    rd_load_d   = reg_re_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    busy_d      = busy_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      stop_d    = 1'b1;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      start_d   = 1'b1;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise) begin
            shift_d = shift_in[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                rw_d = sda_f_q;
                if (shift_in[7:1] == TARGET_ADDR) begin
                  state_d = ST_ADDR_ACK;
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = shift_in;
                state_d = ST_PTR_ACK;
              end else begin
                // Strobe uses the current pointer; the increment lands alongside it.
                reg_we_d    = 1'b1;
                reg_addr_d  = ptr_q;
                reg_wdata_d = shift_in;
                ptr_d       = ptr_q + 8'd1;
                state_d     = ST_WR_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          // First fall after the 8th bit pulls SDA low, the next one releases it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d    = ST_RD;
                reg_re_d   = 1'b1;
                reg_addr_d = ptr_q;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WR;
              end
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RD: begin
          if (rd_load_q) begin
            tx_d      = {i_reg_rdata[6:0], 1'b0};
            sda_oe_d  = ~i_reg_rdata[7];
            bit_cnt_d = 4'd0;
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              mack_d    = 1'b1;
              state_d   = ST_RD_ACK;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end else begin
            tx_d = tx_q;
          end
        end
        ST_RD_ACK: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            mack_d = sda_f_q;
          end else if (scl_fall) begin
            if (!mack_q) begin
              ptr_d      = ptr_q + 8'd1;
              reg_re_d   = 1'b1;
              reg_addr_d = ptr_q + 8'd1;
              state_d    = ST_RD;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            mack_d = mack_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset; filters reset to idle-bus high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      scl_f_q     <= 1'b1;
      sda_f_q     <= 1'b1;
      scl_cnt_q   <= CNT_ZERO;
      sda_cnt_q   <= CNT_ZERO;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= ST_IDLE;
      shift_q     <= 7'd0;
      bit_cnt_q   <= 4'd0;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      tx_q        <= 8'h00;
      sda_oe_q    <= 1'b0;
      rd_load_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      scl_f_q     <= scl_f_d;
      sda_f_q     <= sda_f_d;
      scl_cnt_q   <= scl_cnt_d;
      sda_cnt_q   <= sda_cnt_d;
      scl_p_q     <= scl_p_d;
      sda_p_q     <= sda_p_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      tx_q        <= tx_d;
      sda_oe_q    <= sda_oe_d;
      rd_load_q   <= rd_load_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
    end
  end

  assign b_sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign o_reg_we    = reg_we_q;
  assign o_reg_re    = reg_re_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_busy      = busy_q;
  assign o_start     = start_q;
  assign o_stop      = stop_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master plus a register model
// returning addr ^ 8'hA5 one cycle after each read request.
module tb_i2c_target_regs;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  wire        sda_bus;
  logic       we, re, busy, start_p, stop_p;
  logic [7:0] raddr, wdata;
  logic [7:0] rdata = 8'h00;

  int total = 0;
  int bad = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0, start_cnt = 0, stop_cnt = 0, sda_low_cnt = 0;
  logic [7:0] we_addr [0:31];
  logic [7:0] we_data [0:31];

  always #5 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = sda_m ? 1'bz : 1'b0;

  i2c_target_regs #(.TARGET_ADDR(7'h33), .FILTER_LEN(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .b_sda(sda_bus), .b_scl(scl_m),
    .o_reg_we(we), .o_reg_re(re), .o_reg_addr(raddr), .o_reg_wdata(wdata),
    .i_reg_rdata(rdata), .o_busy(busy), .o_start(start_p), .o_stop(stop_p)
  );

  // Register model: one-cycle read latency.
  always @(posedge clk) begin
    if (re) rdata <= raddr ^ 8'hA5;
  end

  // Strobe monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (we) begin
      if (we_cnt < 32) begin
        we_addr[we_cnt] = raddr;
        we_data[we_cnt] = wdata;
      end
      we_cnt = we_cnt + 1;
    end
    if (re) re_cnt = re_cnt + 1;
    if (we && re) both_cnt = both_cnt + 1;
    if (start_p) start_cnt = start_cnt + 1;
    if (stop_p) stop_cnt = stop_cnt + 1;
    if (sda_m && sda_bus === 1'b0) sda_low_cnt = sda_low_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic do_bit(input logic b, input logic glitch, output logic r);
    sda_m = b; tick(Q);
    scl_m = 1'b1;
    if (glitch) begin
      tick(6); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(Q);
    end else begin
      tick(Q);
    end
    r = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) do_bit(d[i], (i == glitch_bit), r);
    do_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    do_bit(mack, 1'b0, r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(2);
    total++;
    if ({busy, we, re, start_p, stop_p} !== 5'b00000) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {busy, we, re, start_p, stop_p});
    end
    total++;
    if ({raddr, wdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_bus got=%h want=0000", {raddr, wdata});
    end
    total++;
    if (sda_bus !== 1'b1) begin
      bad++; $display("FAIL reset_sda got=%b want=1", sda_bus);
    end
  endtask

  task automatic test_write();
    logic [2:0] a;
    logic       busy_mid;
    int wb = we_cnt, sb = start_cnt, pb = stop_cnt;
    do_start();
    write_byte(8'h66, -1, a[2]);
    busy_mid = busy;
    write_byte(8'h0F, -1, a[1]);
    write_byte(8'hCD, -1, a[0]);
    do_stop();
    tick(Q);
    total++;
    if (a !== 3'b000) begin bad++; $display("FAIL wr_acks got=%b want=000", a); end
    total++;
    if (busy_mid !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b want=1", busy_mid); end
    total++;
    if (we_cnt - wb !== 1) begin bad++; $display("FAIL wr_we_count got=%0d want=1", we_cnt - wb); end
    total++;
    if ({we_addr[wb], we_data[wb]} !== 16'h0FCD) begin
      bad++; $display("FAIL wr_addr_data got=%h want=0fcd", {we_addr[wb], we_data[wb]});
    end
    total++;
    if ({start_cnt - sb, stop_cnt - pb} !== {32'd1, 32'd1}) begin
      bad++; $display("FAIL wr_start_stop got=%0d/%0d want=1/1", start_cnt - sb, stop_cnt - pb);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_burst_wrap();
    logic [3:0] a;
    int wb = we_cnt;
    do_start();
    write_byte(8'h66, -1, a[3]);
    write_byte(8'hFF, -1, a[2]);
    write_byte(8'h11, -1, a[1]);
    write_byte(8'h22, -1, a[0]);
    do_stop();
    tick(Q);
    total++;
    if (a !== 4'b0000) begin bad++; $display("FAIL burst_acks got=%b want=0000", a); end
    total++;
    if (we_cnt - wb !== 2) begin bad++; $display("FAIL burst_we_count got=%0d want=2", we_cnt - wb); end
    total++;
    if ({we_addr[wb], we_data[wb], we_addr[wb+1], we_data[wb+1]} !== 32'hFF11_0022) begin
      bad++; $display("FAIL burst_wrap got=%h want=ff110022",
                      {we_addr[wb], we_data[wb], we_addr[wb+1], we_data[wb+1]});
    end
  endtask

  task automatic test_read();
    logic [2:0] a;
    logic [7:0] d0, d1;
    int wb = we_cnt, rb = re_cnt, sb = start_cnt;
    do_start();
    write_byte(8'h66, -1, a[2]);
    write_byte(8'h10, -1, a[1]);
    do_start();
    write_byte(8'h67, -1, a[0]);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    do_stop();
    tick(Q);
    total++;
    if (a !== 3'b000) begin bad++; $display("FAIL rd_acks got=%b want=000", a); end
    total++;
    if ({d0, d1} !== 16'hB5B4) begin bad++; $display("FAIL rd_data got=%h want=b5b4", {d0, d1}); end
    total++;
    if ({re_cnt - rb, we_cnt - wb} !== {32'd2, 32'd0}) begin
      bad++; $display("FAIL rd_strobes got=re%0d/we%0d want=re2/we0", re_cnt - rb, we_cnt - wb);
    end
    total++;
    if (start_cnt - sb !== 2) begin bad++; $display("FAIL rd_rep_start got=%0d want=2", start_cnt - sb); end
  endtask

  task automatic test_read_persist();
    logic       a;
    logic [7:0] d;
    do_start();
    write_byte(8'h67, -1, a);
    read_byte(1'b1, d);
    do_stop();
    tick(Q);
    total++;
    if ({a, d} !== {1'b0, 8'hB4}) begin bad++; $display("FAIL ptr_persist got=%b/%h want=0/b4", a, d); end
  endtask

  task automatic test_nack_addr();
    logic a;
    logic busy_after;
    int lb = sda_low_cnt, wb = we_cnt, rb = re_cnt;
    do_start();
    write_byte(8'h44, -1, a);
    tick(2);
    busy_after = busy;
    do_stop();
    tick(Q);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL nack_ack_bit got=%b want=1", a); end
    total++;
    if (sda_low_cnt - lb !== 0) begin bad++; $display("FAIL nack_sda_low got=%0d want=0", sda_low_cnt - lb); end
    total++;
    if (busy_after !== 1'b0) begin bad++; $display("FAIL nack_busy got=%b want=0", busy_after); end
    total++;
    if ((we_cnt - wb) + (re_cnt - rb) !== 0) begin
      bad++; $display("FAIL nack_strobes got=%0d want=0", (we_cnt - wb) + (re_cnt - rb));
    end
  endtask

  task automatic test_partial_stop();
    logic [2:0] a;
    logic [7:0] d;
    logic       r;
    int wb = we_cnt;
    do_start();
    write_byte(8'h66, -1, a[2]);
    write_byte(8'h20, -1, a[1]);
    for (int i = 0; i < 4; i++) do_bit(1'b1, 1'b0, r);
    do_stop();
    tick(Q);
    total++;
    if ({we_cnt - wb} !== 32'd0) begin bad++; $display("FAIL partial_we got=%0d want=0", we_cnt - wb); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy got=%b want=0", busy); end
    do_start();
    write_byte(8'h67, -1, a[0]);
    read_byte(1'b1, d);
    do_stop();
    tick(Q);
    total++;
    if ({a, d} !== {3'b000, 8'h85}) begin bad++; $display("FAIL partial_ptr got=%b/%h want=000/85", a, d); end
  endtask

  task automatic test_glitch();
    logic [2:0] a;
    int wb = we_cnt;
    do_start();
    write_byte(8'h66, -1, a[2]);
    write_byte(8'h30, -1, a[1]);
    write_byte(8'h5A, 4, a[0]);
    do_stop();
    tick(Q);
    total++;
    if (a !== 3'b000) begin bad++; $display("FAIL glitch_acks got=%b want=000", a); end
    total++;
    if ({we_cnt - wb} !== 32'd1) begin bad++; $display("FAIL glitch_we_count got=%0d want=1", we_cnt - wb); end
    total++;
    if ({we_addr[wb], we_data[wb]} !== 16'h305A) begin
      bad++; $display("FAIL glitch_data got=%h want=305a", {we_addr[wb], we_data[wb]});
    end
  endtask

  task automatic test_reset_in_read();
    logic       a, b7;
    logic [7:0] d;
    do_start();
    write_byte(8'h67, -1, a);
    do_bit(1'b1, 1'b0, b7);
    total++;
    if ({a, b7, sda_bus} !== 3'b010) begin
      bad++; $display("FAIL rst_rd_pre got=%b want=010", {a, b7, sda_bus});
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({sda_bus, busy} !== 2'b10) begin
      bad++; $display("FAIL rst_rd_release got=%b want=10", {sda_bus, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(Q);
    do_stop();
    tick(Q);
    do_start();
    write_byte(8'h67, -1, a);
    read_byte(1'b1, d);
    do_stop();
    tick(Q);
    total++;
    if ({a, d} !== {1'b0, 8'hA5}) begin bad++; $display("FAIL rst_ptr_cleared got=%b/%h want=0/a5", a, d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_wrap();
    test_read();
    test_read_persist();
    test_nack_addr();
    test_partial_stop();
    test_glitch();
    test_reset_in_read();
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL we_re_overlap got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
